// File: rtl/adc_pkg.sv
// Shared ADC-domain constants and types for the sample-processing blocks.
package adc_pkg;

  localparam int ADC_DATA_W = 12;

  // Wide all-ones pattern; users cast it down to their own sample width.
  localparam logic [31:0] ADC_ALL_ONES = '1;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } adc_state_e;

endpackage

// File: rtl/adc_minmax_track.sv
// Running minimum/maximum of a qualified sample stream, with a synchronous restart.
module adc_minmax_track
  import adc_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W
) (
  input  logic              adc_clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] sample,
  input  logic              valid,
  input  logic              restart,
  output logic [DATA_W-1:0] run_min,
  output logic [DATA_W-1:0] run_max
);

  localparam logic [DATA_W-1:0] MIN_INIT = DATA_W'(ADC_ALL_ONES);

  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;

  // Restart wins over a sample in the same cycle; the caller folds that sample in itself.
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (restart) begin
      min_d = MIN_INIT;
      max_d = '0;
    end else if (valid) begin
      if (sample < min_q) min_d = sample;
      if (sample > max_q) max_d = sample;
    end
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      min_q <= MIN_INIT;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign run_min = min_q;
  assign run_max = max_q;

endmodule

// File: rtl/adc_avg_filter.sv
// Block-average filter: averages windows of 2^LOG2_N samples, reports window min/max
// and a hysteresis level flag on the average.
module adc_avg_filter
  import adc_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int LOG2_N = 4
) (
  input  logic              adc_clk,
  input  logic              reset_n,
  input  logic              response_valid,
  input  logic [DATA_W-1:0] response_data,
  input  logic              clear,
  input  logic [DATA_W-1:0] thresh_hi,
  input  logic [DATA_W-1:0] thresh_lo,
  output logic              avg_valid,
  output logic [DATA_W-1:0] avg_data,
  output logic [DATA_W-1:0] win_min,
  output logic [DATA_W-1:0] win_max,
  output logic              above,
  output adc_state_e        state_dbg
);

  localparam int ACC_W = DATA_W + LOG2_N;

  // response_valid qualifies response_data for exactly one cycle; there is no
  // ready, every qualified sample not coinciding with clear is consumed.
  logic                accept;
  logic                done;
  logic [ACC_W-1:0]    sum;
  logic [DATA_W-1:0]   avg_new;
  logic [DATA_W-1:0]   run_min;
  logic [DATA_W-1:0]   run_max;
  logic [DATA_W-1:0]   fin_min;
  logic [DATA_W-1:0]   fin_max;

  logic [ACC_W-1:0]    acc_q;
  logic [LOG2_N-1:0]   cnt_q;
  adc_state_e          state_q;
  logic                avg_valid_q;
  logic [DATA_W-1:0]   avg_q;
  logic [DATA_W-1:0]   win_min_q;
  logic [DATA_W-1:0]   win_max_q;
  logic                above_q;

  assign accept  = response_valid && !clear;
  assign done    = accept && (&cnt_q);
  assign sum     = acc_q + ACC_W'(response_data);
  assign avg_new = sum[ACC_W-1:LOG2_N];
  assign fin_min = (response_data < run_min) ? response_data : run_min;
  assign fin_max = (response_data > run_max) ? response_data : run_max;

  adc_minmax_track #(
    .DATA_W (DATA_W)
  ) u_minmax (
    .adc_clk (adc_clk),
    .reset_n (reset_n),
    .sample  (response_data),
    .valid   (accept),
    .restart (clear || done),
    .run_min (run_min),
    .run_max (run_max)
  );

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      state_q     <= ST_FILL;
      avg_valid_q <= 1'b0;
      avg_q       <= '0;
      win_min_q   <= '0;
      win_max_q   <= '0;
      above_q     <= 1'b0;
    end else begin
      avg_valid_q <= done;
      if (clear) begin
        acc_q   <= '0;
        cnt_q   <= '0;
        state_q <= ST_FILL;
        above_q <= 1'b0;
      end else if (done) begin
        acc_q     <= '0;
        cnt_q     <= '0;
        state_q   <= ST_RUN;
        avg_q     <= avg_new;
        win_min_q <= fin_min;
        win_max_q <= fin_max;
        // Set is tested first so overlapping thresholds resolve to 1.
        if (avg_new >= thresh_hi)      above_q <= 1'b1;
        else if (avg_new <= thresh_lo) above_q <= 1'b0;
      end else if (accept) begin
        acc_q <= sum;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign avg_valid = avg_valid_q;
  assign avg_data  = avg_q;
  assign win_min   = win_min_q;
  assign win_max   = win_max_q;
  assign above     = above_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_adc_avg_filter.sv
// Bench for adc_avg_filter: directed and random windows checked against a window-level model.
module tb_adc_avg_filter;
  import adc_pkg::*;

  localparam int W = 12;
  localparam int N = 16;

  logic          adc_clk = 1'b0;
  logic          reset_n;
  logic          response_valid;
  logic [W-1:0]  response_data;
  logic          clear;
  logic [W-1:0]  thresh_hi;
  logic [W-1:0]  thresh_lo;
  logic          avg_valid;
  logic [W-1:0]  avg_data;
  logic [W-1:0]  win_min;
  logic [W-1:0]  win_max;
  logic          above;
  adc_state_e    state_dbg;

  adc_avg_filter #(.DATA_W(W), .LOG2_N(4)) dut (
    .adc_clk        (adc_clk),
    .reset_n        (reset_n),
    .response_valid (response_valid),
    .response_data  (response_data),
    .clear          (clear),
    .thresh_hi      (thresh_hi),
    .thresh_lo      (thresh_lo),
    .avg_valid      (avg_valid),
    .avg_data       (avg_data),
    .win_min        (win_min),
    .win_max        (win_max),
    .above          (above),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 adc_clk = ~adc_clk;

  int unsigned cyc = 0;
  always @(posedge adc_clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (window level) ----------------
  typedef struct packed {
    logic [31:0]  cyc;
    logic         above;
    logic [W-1:0] mx;
    logic [W-1:0] mn;
    logic [W-1:0] avg;
  } exp_t;

  exp_t          exp_q[$];
  logic [W-1:0]  win_q[$];
  logic          model_above = 1'b0;
  logic [W-1:0]  last_avg = '0;
  int            pulses_exp = 0;
  int            pulses_seen = 0;

  task automatic model_accept(input logic [W-1:0] d, input int unsigned c);
    int unsigned sum;
    logic [W-1:0] mn, mx, avg;
    exp_t e;
    win_q.push_back(d);
    if (win_q.size() == N) begin
      sum = 0;
      mn  = win_q[0];
      mx  = win_q[0];
      foreach (win_q[i]) begin
        sum += win_q[i];
        if (win_q[i] < mn) mn = win_q[i];
        if (win_q[i] > mx) mx = win_q[i];
      end
      avg = W'(sum / N);
      if (avg >= thresh_hi)      model_above = 1'b1;
      else if (avg <= thresh_lo) model_above = 1'b0;
      e.cyc   = c;
      e.above = model_above;
      e.mx    = mx;
      e.mn    = mn;
      e.avg   = avg;
      exp_q.push_back(e);
      last_avg = avg;
      pulses_exp++;
      win_q.delete();
    end
  endtask

  exp_t mon_e;
  always @(negedge adc_clk) begin
    if (reset_n === 1'b1 && avg_valid === 1'b1) begin
      pulses_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_cycle", cyc, mon_e.cyc);
        check("pulse_avg", 32'(avg_data), 32'(mon_e.avg));
        check("pulse_min", 32'(win_min), 32'(mon_e.mn));
        check("pulse_max", 32'(win_max), 32'(mon_e.mx));
        check("pulse_above", 32'(above), 32'(mon_e.above));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge adc_clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] d);
    response_valid = 1'b1;
    response_data  = d;
    @(posedge adc_clk);
    #1;
    response_valid = 1'b0;
    model_accept(d, cyc);
  endtask

  task automatic send_window(input logic [W-1:0] d, input int gap);
    for (int i = 0; i < N; i++) begin
      send(d);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic do_clear(input logic with_valid, input logic [W-1:0] d);
    response_valid = with_valid;
    response_data  = d;
    clear          = 1'b1;
    @(posedge adc_clk);
    #1;
    clear          = 1'b0;
    response_valid = 1'b0;
    win_q.delete();
    model_above = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(avg_valid), 32'd0);
    check({tag, "_avg"},   32'(avg_data),  32'd0);
    check({tag, "_min"},   32'(win_min),   32'd0);
    check({tag, "_max"},   32'(win_max),   32'd0);
    check({tag, "_above"}, 32'(above),     32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(ST_FILL));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset_n        = 1'b0;
    response_valid = 1'b0;
    response_data  = '0;
    clear          = 1'b0;
    thresh_hi      = 12'h900;
    thresh_lo      = 12'h700;

    repeat (2) @(negedge adc_clk);
    check_reset_outputs("por");
    @(posedge adc_clk);
    #1;
    reset_n = 1'b1;
    idle(2);

    // steady input with wide spacing
    send_window(12'h800, 99);
    check("steady_avg", 32'(avg_data), 32'h800);
    check("steady_above", 32'(above), 32'd0);
    check("steady_state", 32'(state_dbg), 32'(ST_RUN));

    // hysteresis path 0x950 -> 0x800 -> 0x6F0
    send_window(12'h950, 0);
    check("hyst_950", 32'(above), 32'd1);
    send_window(12'h800, 0);
    check("hyst_800_hold", 32'(above), 32'd1);
    send_window(12'h6F0, 0);
    check("hyst_6f0", 32'(above), 32'd0);
    idle(3);

    // ramp with truncation
    for (int i = 0; i < N; i++) send(W'(i));
    check("ramp_avg", 32'(avg_data), 32'd7);
    check("ramp_min", 32'(win_min), 32'd0);
    check("ramp_max", 32'(win_max), 32'd15);
    idle(3);

    // full scale, two back-to-back windows
    for (int i = 0; i < 2 * N; i++) send(12'hFFF);
    check("full_avg", 32'(avg_data), 32'hFFF);
    idle(3);

    // clear mid-window together with a valid sample
    for (int i = 0; i < 10; i++) send(12'h100);
    do_clear(1'b1, 12'h100);
    check("clear_above", 32'(above), 32'd0);
    check("clear_avg_hold", 32'(avg_data), 32'hFFF);
    check("clear_state", 32'(state_dbg), 32'(ST_FILL));
    check("clear_no_pulse", 32'(avg_valid), 32'd0);
    for (int i = 0; i < N - 1; i++) send(12'h200);
    check("clear_avg_hold2", 32'(avg_data), 32'hFFF);
    send(12'h200);
    check("clear_avg_new", 32'(avg_data), 32'h200);
    idle(3);

    // overlapping thresholds: set wins
    thresh_lo = 12'hA00;
    thresh_hi = 12'h900;
    send_window(12'h950, 0);
    check("overlap_above", 32'(above), 32'd1);
    thresh_hi = 12'h900;
    thresh_lo = 12'h700;
    idle(3);

    // asynchronous reset mid-window
    for (int i = 0; i < 8; i++) send(12'h123);
    #3 reset_n = 1'b0;
    win_q.delete();
    model_above = 1'b0;
    last_avg = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge adc_clk);
      check_reset_outputs("midrst");
    end
    #2 reset_n = 1'b1;
    @(posedge adc_clk);
    #1;
    send_window(12'h300, 0);
    check("rst_avg", 32'(avg_data), 32'h300);
    idle(3);

    // randomized windows, random gaps, thresholds and occasional clears
    for (int w = 0; w < 8; w++) begin
      int base;
      if ($urandom_range(0, 2) == 0) begin
        thresh_hi = W'($urandom_range(12'h600, 12'hC00));
        thresh_lo = W'($urandom_range(12'h200, 12'hA00));
      end
      base = $urandom_range(0, 4095);
      for (int i = 0; i < N; i++) begin
        int v;
        v = base + $urandom_range(0, 512) - 256;
        if (v < 0) v = 0;
        if (v > 4095) v = 4095;
        send(W'(v));
        if (w == 5 && i == 6) begin
          do_clear(1'(($urandom_range(0, 1))), W'($urandom_range(0, 4095)));
          check("rand_clear_above", 32'(above), 32'd0);
          check("rand_clear_hold", 32'(avg_data), 32'(last_avg));
        end
        idle($urandom_range(0, 2));
      end
    end
    for (int i = 0; i < N; i++) send(W'($urandom_range(0, 4095)));
    idle(5);

    check("pulse_count", 32'(pulses_seen), 32'(pulses_exp));
    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_avg_filter.md
# adc_avg_filter

Block-average filter that consumes the ADC response stream (`response_valid` / `response_data`) in parallel with the sample-capture stage. It accumulates a fixed window of 2^LOG2_N samples and emits one averaged sample per window, together with the window minimum and maximum. It also drives a hysteresis level flag for the G-sensor display logic.

## Interface
- DATA_W, 12: sample width in bits.
- LOG2_N, 4: log2 of the window length (N = 16 samples). Legal range is 1..8.
- adc_clk  in  1  ADC domain clock. All logic is in this domain.
- reset_n  in  1  Reset, asynchronous, active-low. The clock is adc_clk.
- response_valid  in  1  One-cycle qualifier for response_data.
- response_data  in  DATA_W  Raw ADC sample.
- clear  in  1  Synchronous window abort. Level-sensitive.
- thresh_hi  in  DATA_W  Set threshold for `above`. Must be quasi-static.
- thresh_lo  in  DATA_W  Release threshold for `above`. Must be quasi-static.
- avg_valid  out  1  One-cycle pulse when a new average is available.
- avg_data  out  DATA_W  Window average, truncated.
- win_min  out  DATA_W  Minimum sample of the last completed window.
- win_max  out  DATA_W  Maximum sample of the last completed window.
- above  out  1  Hysteresis level flag.

## Operation
- State machine has two states.
  - FILL: entered from reset or clear. No window has completed yet. `above` is held at 0.
  - RUN: entered after the first completed window. Thereafter it stays in RUN until reset or clear.
- Accumulator width is DATA_W+LOG2_N (16 bits by default). It never overflows; worst case 0xFFF×16 = 0xFFF0.
- Sample counter width is LOG2_N.
- Each accepted sample (`response_valid`=1, `clear`=0) does the following:
  - acc += response_data.
  - cnt++.
  - run_min and run_max are updated.
- Window completion: on an accepted sample with cnt == N-1:
  - avg_data <= (acc + response_data) >> LOG2_N. Truncation, no rounding.
  - win_min and win_max are loaded with their final values, which include this sample.
  - avg_valid <= 1.
  - acc and cnt restart at 0. run_min restarts at all-ones; run_max restarts at 0.
  - State goes to RUN.
- Hysteresis is evaluated on the new average, in the same edge that loads avg_data:
  - If avg >= thresh_hi, `above` <= 1.
  - Else if avg <= thresh_lo, `above` <= 0.
  - Otherwise `above` holds.
  - If the thresholds overlap (thresh_lo >= thresh_hi), the set condition wins.
- `clear` behaviour:
  - acc and cnt go to 0; run_min and run_max go to their restart values; state goes to FILL.
  - A sample presented in the same cycle as `clear` is discarded.
  - avg_data, win_min and win_max hold their values.
  - `above` goes to 0.
  - avg_valid is 0 in the cycle after `clear`.
- Output values while reset_n is low:
  - avg_valid = 0, avg_data = 0, win_min = 0, win_max = 0, above = 0.
  - State = FILL; acc = 0; cnt = 0.
  - run_min = all-ones; run_max = 0.
- Reset asserted mid-window drops the partial window. Output pulses are only produced by full windows.
- Samples arriving on back-to-back cycles are all accepted; there is no backpressure and no overrun condition.

## Timing
- Latency: the Nth sample is valid in cycle k, so avg_valid = 1 in cycle k+1.
  - avg_data, win_min, win_max and above are valid and stable from cycle k+1 until the next window completes.
- avg_valid is high for exactly one cycle per window, including at minimum spacing (N consecutive valid cycles).
- There is no combinational path from any input to any output. All outputs are registered.
- Thresholds are sampled only at the completion edge; changes between windows are allowed.

## Structure
- Shared package `adc_pkg`:
  - ADC_DATA_W = 12.
  - The FILL/RUN state enum type.
  - ADC_ALL_ONES constant, used for the run_min restart value.
- One sub-module, `adc_minmax_track`.
  - Parameterised by DATA_W.
  - Inputs: sample, valid, restart. Outputs: run_min, run_max.
  - It is shared with later peak-detect blocks.
- The top level holds the accumulator, counter, state machine, output registers and hysteresis logic.

## Test plan
- Steady input: 16 valid samples of 0x800 spaced 100 cycles apart → one avg_valid pulse; avg_data = 0x800, win_min = win_max = 0x800.
- Ramp with truncation: back-to-back samples 0..15 → avg_data = 7 (sum 120 >> 4), win_min = 0, win_max = 15.
  - avg_valid appears exactly 1 cycle after the 16th sample.
- Full scale, no overflow: 32 samples of 0xFFF back-to-back → two pulses, both with avg_data = 0xFFF, spaced 16 cycles apart.
- Hysteresis with thresh_hi = 0x900, thresh_lo = 0x700; window averages 0x800 → 0x950 → 0x800 → 0x6F0 → `above` = 0, 1, 1, 0.
  - Also test the overlap case: thresh_lo = 0xA00, thresh_hi = 0x900, average 0x950 → `above` = 1.
- Clear mid-window: 10 samples of 0x100, then clear asserted together with a valid sample, then 16 samples of 0x200 → a single pulse with avg_data = 0x200.
  - The prior avg_data is held throughout, and `above` = 0 after the clear.
- Reset mid-window: reset_n is pulsed low for 3 cycles after sample 8 of a window, asynchronously to adc_clk, then 16 samples of 0x300 are applied.
  - All outputs read 0 during reset.
  - Exactly one pulse follows, with avg_data = 0x300.
